// File: rtl/div32_seq_if.sv
// Request/response bundle between the execute stage and the sequential divider.
interface div32_seq_if #(
  parameter int W = 32
);
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         busy;
  logic         done;
  logic [W-1:0] f;

  modport master (output start, op, x, y, input busy, done, f);
  modport slave  (input start, op, x, y, output busy, done, f);
endinterface

// File: rtl/div32_seq.sv
// Radix-2 restoring divider for RV32 DIV/DIVU/REM/REMU: one trial subtraction per clock,
// 32 iterations, plus a one-edge path for divide-by-zero and signed overflow.
module div32_seq #(
  parameter int W     = 32,
  parameter int CNT_W = 5
) (
  input logic        clk,
  input logic        rst_n,
  div32_seq_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_SPEC = 2'd3;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  logic [1:0]       state, op_r;
  logic             sign_q, sign_r, busy_r, done_r;
  logic [W-1:0]     q, rem, dvsr, f_r;
  logic [CNT_W-1:0] cnt;

  logic         sgn_in, is_spec;
  logic [W-1:0] x_abs, y_abs;
  logic [W:0]   diff;

  always_comb begin
    sgn_in  = ~bus.op[0];
    x_abs   = (sgn_in && bus.x[W-1]) ? -bus.x : bus.x;
    y_abs   = (sgn_in && bus.y[W-1]) ? -bus.y : bus.y;
    is_spec = (bus.y == '0) || (sgn_in && bus.x == MIN_NEG && bus.y == '1);
    // rem < dvsr always holds, so bit W of the 33-bit difference is a true sign bit
    diff    = {rem, q[W-1]} - {1'b0, dvsr};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      op_r   <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      q      <= '0;
      rem    <= '0;
      dvsr   <= '0;
      f_r    <= '0;
      cnt    <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: if (bus.start) begin
          op_r   <= bus.op;
          sign_q <= sgn_in & (bus.x[W-1] ^ bus.y[W-1]);
          sign_r <= sgn_in & bus.x[W-1];
          q      <= x_abs;
          dvsr   <= y_abs;
          rem    <= '0;
          cnt    <= '0;
          busy_r <= 1'b1;
          state  <= is_spec ? S_SPEC : S_CALC;
        end
        S_CALC: begin
          if (!diff[W]) begin
            rem <= diff[W-1:0];
            q   <= {q[W-2:0], 1'b1};
          end else begin
            rem <= {rem[W-2:0], q[W-1]};
            q   <= {q[W-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(W-1)) state <= S_FIX;
        end
        S_FIX: begin
          case (op_r)
            2'b00:   f_r <= sign_q ? -q : q;
            2'b10:   f_r <= sign_r ? -rem : rem;
            2'b01:   f_r <= q;
            default: f_r <= rem;
          endcase
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          // q still holds |x|; re-applying the dividend sign reproduces the original x
          if (dvsr == '0) f_r <= op_r[1] ? (sign_r ? -q : q) : '1;
          else            f_r <= op_r[1] ? '0 : MIN_NEG;
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.f    = f_r;
endmodule

// File: doc/div32_seq.md
Name: div32_seq

Overview:
- Multi-cycle 32-bit integer divider for the RV32 ALU. It implements DIV, DIVU, REM and REMU with RISC-V M-extension semantics.
- Arithmetic is radix-2 restoring division: one 33-bit trial subtraction per clock, 32 iterations, no hardware beyond one subtractor and shift registers.
- It sits beside the single-cycle add/sub path and is driven by the execute stage through a start/busy/done handshake.

Parameters:
- W, 32, operand and result width. Only 32 is verified.
- CNT_W, 5, width of the iteration counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request pulse; sampled only when busy=0
- op  in  2  00 DIV (signed quotient), 01 DIVU, 10 REM (signed remainder), 11 REMU
- x  in  32  dividend; sampled with start
- y  in  32  divisor; sampled with start
- busy  out  1  high from the accept edge until the edge that raises done
- done  out  1  single-cycle pulse; f is valid while done=1
- f  out  32  result register; holds its value until the next done

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - busy=0, done=0, f=0, and all internal registers are 0.
- States: IDLE, CALC, FIX, SPEC.
- IDLE:
  - On an edge with start=1, latch op.
  - Signed ops: latch |x| and |y|, plus sign_q = x[31]^y[31] and sign_r = x[31]. Unsigned ops: latch raw values.
  - Clear the remainder register. Load the quotient register with the (abs) dividend. Set cnt=0 and busy=1.
  - If y==0, or op is signed with x==32'h80000000 and y==32'hFFFFFFFF, go to SPEC. Otherwise go to CALC.
- CALC, one iteration per edge:
  - Form {rem[31:0], q[31]} minus {1'b0, divisor} in 33 bits.
  - If the result is non-negative: rem takes the difference and q shifts left with 1. Otherwise rem takes {rem[30:0], q[31]} and q shifts left with 0.
  - cnt increments each edge. Go to FIX on the edge where cnt==31, i.e. after 32 iterations.
- FIX, one edge:
  - DIV: f = sign_q ? -q : q.
  - REM: f = sign_r ? -rem : rem.
  - DIVU: f = q.
  - REMU: f = rem.
  - done=1, busy=0, next state IDLE.
- SPEC, one edge:
  - Divide by zero: DIV and DIVU give f=32'hFFFFFFFF. REM and REMU give f = the original x.
  - Signed overflow: DIV gives f=32'h80000000, REM gives f=0.
  - done=1, busy=0, next state IDLE.
- Latency, with the accept edge as edge 0:
  - Normal division: done and f update at edge 33.
  - Special cases: done and f update at edge 1.
- done is high for exactly one cycle. The request immediately after it may be accepted in the cycle where done=1, so back-to-back throughput is one request per 34 cycles.
- start while busy=1 is ignored. x, y and op may change freely after acceptance.
- Remainder sign follows the dividend and quotient truncates toward zero, e.g. -7/2 gives q=-3, r=-1.
- rst_n low during CALC aborts the operation immediately: no done and f=0. The next start after release behaves normally.
- Operands are never read combinationally into f. f changes only on FIX/SPEC edges or on reset.

Test Plan:
- DIVU x=100, y=7 -> done exactly 33 edges after accept, f=14. REMU with the same operands -> f=2. busy high for edges 0..32.
- DIV x=-7 (32'hFFFFFFF9), y=2 -> f=32'hFFFFFFFD. REM with the same operands -> f=32'hFFFFFFFF. DIV x=7, y=-2 -> f=32'hFFFFFFFD.
- Divide by zero with x=32'h12345678, y=0 -> done one edge after accept. DIV/DIVU give f=32'hFFFFFFFF; REM/REMU give f=32'h12345678.
- Overflow: DIV x=32'h80000000, y=32'hFFFFFFFF -> f=32'h80000000 at edge 1. REM -> f=0. DIVU with the same operands -> f=0 after 33 edges.
- Pulse start again at edge 10 of a running op with different operands -> ignored, first result unchanged. New start in the done cycle -> accepted, second correct result 34 cycles later.
- Assert rst_n=0 at edge 15 of CALC -> busy=0, done=0, f=0 asynchronously. After release, DIVU 32'hFFFFFFFF/1 -> f=32'hFFFFFFFF. Finish with a random sweep of 10k operands against a reference model.
